// File: rtl/mem_stage.sv
// Memory-access stage: holds one instruction from execute, waits for the
// data-SRAM response of a memory request, aligns/extends load data and
// hands the result to write-back. Also drives the decode forwarding port.
//
// Handshake (both sides): a transfer happens on a rising edge where the
// sender's valid and the receiver's allowin are both high. valid is
// held with a stable bus until the transfer happens. allowin may depend
// combinationally on the downstream allowin and on data_sram_data_ok.
module mem_stage (
  input  logic        clk,
  input  logic        resetn,
  input  logic        ex_to_mem_valid,
  input  logic [74:0] ex_to_mem_bus,
  output logic        mem_allowin,
  input  logic        data_sram_data_ok,
  input  logic [31:0] data_sram_rdata,
  input  logic        wb_allowin,
  output logic        mem_to_wb_valid,
  output logic [69:0] mem_to_wb_bus,
  output logic        mem_fwd_we,
  output logic [4:0]  mem_fwd_waddr,
  output logic [31:0] mem_fwd_wdata,
  output logic        mem_fwd_block
);

  logic        mem_valid_q, mem_valid_d;
  logic [74:0] ex_to_mem_reg_q, ex_to_mem_reg_d;
  logic        data_buf_valid_q, data_buf_valid_d;
  logic [31:0] data_buf_q, data_buf_d;

  // Fields of the captured instruction
  logic        mem_req;
  logic        res_from_mem;
  logic [2:0]  ld_type;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] alu_result;
  logic [31:0] pc;

  assign {mem_req, res_from_mem, ld_type, rf_we, rf_waddr, alu_result, pc} = ex_to_mem_reg_q;

  // A response only counts when it belongs to the instruction in the stage;
  // stray pulses are filtered here so they cannot touch any state.
  logic data_ok_hit;
  logic mem_ready_go;
  logic mem_leave;

  assign data_ok_hit     = data_sram_data_ok & mem_valid_q & mem_req & ~data_buf_valid_q;
  assign mem_ready_go    = ~mem_req | data_ok_hit | data_buf_valid_q;
  assign mem_allowin     = ~mem_valid_q | (mem_ready_go & wb_allowin);
  assign mem_to_wb_valid = mem_valid_q & mem_ready_go;
  assign mem_leave       = mem_valid_q & mem_ready_go & wb_allowin;

  logic [31:0] raw_word;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] load_data;
  logic [31:0] rf_wdata;

  // Select the load word source and align/extend it by ld_type and offset
  always_comb begin
    raw_word = data_buf_valid_q ? data_buf_q : data_sram_rdata;
    ld_byte  = raw_word[{alu_result[1:0], 3'b000} +: 8];
    ld_half  = alu_result[1] ? raw_word[31:16] : raw_word[15:0];
    case (ld_type)
      3'b001:  load_data = {{24{ld_byte[7]}}, ld_byte};
      3'b101:  load_data = {24'b0, ld_byte};
      3'b010:  load_data = {{16{ld_half[15]}}, ld_half};
      3'b110:  load_data = {16'b0, ld_half};
      default: load_data = raw_word;
    endcase
    rf_wdata = res_from_mem ? load_data : alu_result;
  end

  assign mem_to_wb_bus = {rf_we, rf_waddr, rf_wdata, pc};
  assign mem_fwd_we    = mem_valid_q & rf_we;
  assign mem_fwd_waddr = rf_waddr;
  assign mem_fwd_wdata = rf_wdata;
  assign mem_fwd_block = mem_valid_q & res_from_mem & ~data_sram_data_ok & ~data_buf_valid_q;

  // Next-state: pipeline capture and response buffering while write-back stalls
  always_comb begin
    mem_valid_d      = mem_valid_q;
    ex_to_mem_reg_d  = ex_to_mem_reg_q;
    data_buf_valid_d = data_buf_valid_q;
    data_buf_d       = data_buf_q;
    if (mem_allowin) begin
      mem_valid_d = ex_to_mem_valid;
    end
    if (ex_to_mem_valid && mem_allowin) begin
      ex_to_mem_reg_d = ex_to_mem_bus;
    end
    // Departure clears the buffer so a newly captured entry starts empty
    if (mem_leave) begin
      data_buf_valid_d = 1'b0;
    end else if (data_ok_hit && !wb_allowin) begin
      data_buf_valid_d = 1'b1;
      data_buf_d       = data_sram_rdata;
    end
  end

  // State registers with asynchronous active-low reset
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      mem_valid_q      <= 1'b0;
      ex_to_mem_reg_q  <= '0;
      data_buf_valid_q <= 1'b0;
      data_buf_q       <= '0;
    end else begin
      mem_valid_q      <= mem_valid_d;
      ex_to_mem_reg_q  <= ex_to_mem_reg_d;
      data_buf_valid_q <= data_buf_valid_d;
      data_buf_q       <= data_buf_d;
    end
  end

endmodule

// File: doc/mem_stage.md
# mem_stage

Memory-access stage of the five-stage pipeline, sitting between the execute stage and write-back and acting as the transmitter of the mem-to-wb valid/allowin handshake and 70-bit bus. It accepts one instruction per cycle from execute and waits for the data-SRAM response of any memory request issued in execute. It byte- and halfword-aligns and extends load data, then forwards the instruction to write-back. It also exports a forwarding/stall port to decode.

## Interface
- No parameters. Bus widths are fixed: ex-to-mem 75 bits, mem-to-wb 70 bits.
- clk  in  1  pipeline clock, all state on rising edge
- resetn  in  1  asynchronous, active-low reset
- ex_to_mem_valid  in  1  execute holds a valid instruction for this stage
- ex_to_mem_bus  in  75  {mem_req[74], res_from_mem[73], ld_type[72:70], rf_we[69], rf_waddr[68:64], alu_result[63:32], pc[31:0]}
- mem_allowin  out  1  this stage can accept from execute this cycle
- data_sram_data_ok  in  1  one-cycle response pulse for the outstanding request (load or store)
- data_sram_rdata  in  32  read data, valid only with data_ok
- wb_allowin  in  1  write-back can accept
- mem_to_wb_valid  out  1  bus below is valid for write-back
- mem_to_wb_bus  out  70  {rf_we[69], rf_waddr[68:64], rf_wdata[63:32], pc[31:0]}
- mem_fwd_we  out  1  valid instruction in stage writes the register file
- mem_fwd_waddr  out  5  destination register
- mem_fwd_wdata  out  32  final write data (ALU result or aligned load data)
- mem_fwd_block  out  1  valid load in stage whose data is not yet available; decode must stall on match

## Operation
- State: mem_valid, 75-bit ex_to_mem_reg, data_buf_valid, 32-bit data_buf.
- mem_ready_go = ~mem_req | data_sram_data_ok | data_buf_valid.
- mem_allowin = ~mem_valid | (mem_ready_go & wb_allowin).
- mem_to_wb_valid = mem_valid & mem_ready_go.
- When mem_allowin is high: mem_valid <= ex_to_mem_valid. ex_to_mem_reg loads only when ex_to_mem_valid & mem_allowin.
- Response buffer: data_ok while mem_valid & mem_req & ~data_buf_valid & ~wb_allowin sets data_buf_valid and captures rdata. data_buf_valid clears when the instruction leaves (mem_valid & mem_ready_go & wb_allowin).
- data_ok arriving while ~mem_valid, ~mem_req, or data_buf_valid is a protocol violation. It is ignored and must not change any state.
- Raw load word = data_buf_valid ? data_buf : data_sram_rdata. Byte offset = alu_result[1:0].
- ld_type: 000 ld.w (offset must be 0); 001 ld.b sign-extend byte[offset]; 101 ld.bu zero-extend; 010 ld.h sign-extend half[offset[1]]; 110 ld.hu zero-extend. Other codes behave as ld.w.
- rf_wdata = res_from_mem ? aligned load data : alu_result. Stores have mem_req=1, res_from_mem=0, rf_we=0.
- mem_to_wb_bus rf_we = stored rf_we (not gated; write-back gates with its valid). mem_fwd_we = mem_valid & rf_we.
- mem_fwd_block = mem_valid & res_from_mem & ~data_sram_data_ok & ~data_buf_valid.

## Timing
- Async reset: mem_valid=0, data_buf_valid=0, ex_to_mem_reg=0, data_buf=0. Hence mem_allowin=1, mem_to_wb_valid=0, mem_to_wb_bus=0, all mem_fwd_* = 0.
- Non-memory instruction: minimum one cycle in stage, presented to write-back the cycle after capture.
- Memory instruction: leaves in the data_ok cycle if wb_allowin, else from data_buf on a later cycle. The data_ok to mem_to_wb_valid/mem_allowin path is combinational.
- Back-to-back: capture and departure in the same cycle are allowed. The new entry never inherits data_buf_valid.
- Reset mid-wait discards the instruction and any buffered data. A late data_ok after reset is ignored.

## Test plan
- Reset asserted mid-load -> mem_valid=0, mem_allowin=1, all outputs 0; subsequent stray data_ok ignored.
- ALU op, rf_we=1, waddr=5, alu_result=0x1234_5678, wb_allowin=1 -> next cycle mem_to_wb_valid=1, bus={1,5,0x12345678,pc}; mem_fwd_we=1, block=0.
- ld.b addr=...03, rdata=0x80FF_0000, data_ok 2 cycles after capture -> block=1 for 2 cycles; wdata=0xFFFF_FF80 in the data_ok cycle; mem_allowin=0 while waiting.
- ld.hu addr=...02, rdata=0xBEEF_1234 with wb_allowin=0 at data_ok -> buffered; when wb_allowin=1 two cycles later, wdata=0x0000_BEEF; block stays 0 after data_ok.
- Store (mem_req=1, rf_we=0) -> stalls until data_ok, then mem_to_wb_valid=1 with rf_we=0.
- Continuous ALU stream with wb_allowin=1 -> one instruction per cycle; then toggling wb_allowin -> no instruction lost or duplicated (pc sequence checked).
